// File: rtl/sys_clk_timer_pkg.sv
// Shared definitions for the system interval timer sequencer: timer register
// map, control register bit positions, the sequencer state encoding and a
// helper that guards against a zero load value.
package sys_clk_timer_pkg;

    // Timer s1 register map
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    // Control register bit positions
    localparam int CTL_ITO_BIT   = 0;
    localparam int CTL_CONT_BIT  = 1;
    localparam int CTL_START_BIT = 2;
    localparam int CTL_STOP_BIT  = 3;

    // START | CONT | ITO
    localparam logic [3:0] CTL_RUN = 4'h7;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRG_L    = 4'd1,
        ST_PRG_H    = 4'd2,
        ST_PRG_ST   = 4'd3,
        ST_PRG_CTL  = 4'd4,
        ST_IRQ_CLR  = 4'd5,
        ST_SNAP_WR  = 4'd6,
        ST_SNAP_RL  = 4'd7,
        ST_SNAP_RH  = 4'd8,
        ST_SNAP_CAP = 4'd9
    } tmr_state_e;

    // A zero period would make the timer fire once and stall, so use 1 instead.
    function automatic logic [31:0] fix_load(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/sys_clk_timer_ctrl.sv
// Avalon-MM master sequencer for the system interval timer. Programs the
// timer at boot, clears its timeout in hardware and turns every serviced
// timeout into a tick pulse and a tick count. Also accepts period
// reprogramming requests and atomic 32-bit counter snapshot requests.
//
// Handshake: cfg_req and snap_req are level requests held high until their
// one-cycle response (cfg_ack / snap_valid). In the response cycle the
// request is ignored even if still high; a request still high in the cycle
// after that is accepted as a new one.
//
// Bus outputs are registered with the access belonging to the state being
// entered, so the access of a state is on the bus while the FSM sits in it.
// The one exception is boot: reset leaves the FSM in PRG_L with an idle bus,
// so PRG_L issues its own write on the first clock and only then advances.
module sys_clk_timer_ctrl
    import sys_clk_timer_pkg::*;
#(
    parameter logic [31:0] DEFAULT_LOAD = 32'd59999
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    input  logic        cfg_req,
    input  logic [31:0] cfg_load,
    output logic        cfg_ack,
    input  logic        snap_req,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic        busy
);

    tmr_state_e  state;
    logic [31:0] load_q;
    logic        boot_pend;
    logic        cfg_run;
    logic [31:0] cfg_load_fixed;

    // Requested load with the zero-period guard applied
    assign cfg_load_fixed = fix_load(cfg_load);

    // Sequencer FSM with registered bus, handshake and tick outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_PRG_L;
            load_q         <= fix_load(DEFAULT_LOAD);
            boot_pend      <= 1'b1;
            cfg_run        <= 1'b0;
            tmr_address    <= 3'd0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= 16'd0;
            cfg_ack        <= 1'b0;
            snap_valid     <= 1'b0;
            snap_value     <= 32'd0;
            tick           <= 1'b0;
            tick_count     <= 32'd0;
            busy           <= 1'b0;
        end else begin
            cfg_ack        <= 1'b0;
            snap_valid     <= 1'b0;
            tick           <= 1'b0;
            busy           <= 1'b1;
            tmr_address    <= ADDR_STATUS;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= 16'd0;

            case (state)
                ST_IDLE: begin
                    if (tmr_irq) begin
                        state          <= ST_IRQ_CLR;
                        tmr_address    <= ADDR_STATUS;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                    end else if (cfg_req && !cfg_ack) begin
                        state          <= ST_PRG_L;
                        load_q         <= cfg_load_fixed;
                        cfg_run        <= 1'b1;
                        tmr_address    <= ADDR_PERIOD_L;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_writedata  <= cfg_load_fixed[15:0];
                    end else if (snap_req && !snap_valid) begin
                        state          <= ST_SNAP_WR;
                        tmr_address    <= ADDR_SNAP_L;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_PRG_L: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    if (boot_pend) begin
                        boot_pend     <= 1'b0;
                        tmr_address   <= ADDR_PERIOD_L;
                        tmr_writedata <= load_q[15:0];
                    end else begin
                        state         <= ST_PRG_H;
                        tmr_address   <= ADDR_PERIOD_H;
                        tmr_writedata <= load_q[31:16];
                    end
                end

                ST_PRG_H: begin
                    state          <= ST_PRG_ST;
                    tmr_address    <= ADDR_STATUS;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                end

                ST_PRG_ST: begin
                    state          <= ST_PRG_CTL;
                    tmr_address    <= ADDR_CONTROL;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_writedata  <= {12'd0, CTL_RUN};
                end

                ST_PRG_CTL: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    cfg_ack <= cfg_run;
                    cfg_run <= 1'b0;
                end

                ST_IRQ_CLR: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    tick       <= 1'b1;
                    tick_count <= tick_count + 32'd1;
                end

                ST_SNAP_WR: begin
                    state          <= ST_SNAP_RL;
                    tmr_address    <= ADDR_SNAP_L;
                    tmr_chipselect <= 1'b1;
                end

                ST_SNAP_RL: begin
                    state          <= ST_SNAP_RH;
                    tmr_address    <= ADDR_SNAP_H;
                    tmr_chipselect <= 1'b1;
                end

                ST_SNAP_RH: begin
                    state            <= ST_SNAP_CAP;
                    snap_value[15:0] <= tmr_readdata;
                end

                ST_SNAP_CAP: begin
                    state             <= ST_IDLE;
                    busy              <= 1'b0;
                    snap_value[31:16] <= tmr_readdata;
                    snap_valid        <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_clk_timer_ctrl.sv
module tb_sys_clk_timer_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;
  logic        cfg_req;
  logic [31:0] cfg_load;
  logic        cfg_ack;
  logic        snap_req;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic        tick;
  logic [31:0] tick_count;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sys_clk_timer_ctrl #(.DEFAULT_LOAD(32'd59999)) dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .cfg_req(cfg_req), .cfg_load(cfg_load), .cfg_ack(cfg_ack),
    .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value),
    .tick(tick), .tick_count(tick_count), .busy(busy)
  );

  // ---------------- interval timer model ----------------
  localparam logic [31:0] SNAP_FORCE = 32'h0001_2345;
  logic [15:0] m_per_l, m_per_h, m_snap_l, m_snap_h;
  logic [31:0] m_cnt;
  logic        m_run, m_cont, m_ito, m_to;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_per_l <= 16'hFFFF; m_per_h <= 16'hFFFF;
      m_snap_l <= 16'd0; m_snap_h <= 16'd0;
      m_cnt <= 32'd0; m_run <= 1'b0; m_cont <= 1'b0; m_ito <= 1'b0; m_to <= 1'b0;
      tmr_readdata <= 16'd0;
    end else begin
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_to  <= 1'b1;
          m_cnt <= {m_per_h, m_per_l};
          m_run <= m_cont;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: if (!(m_run && m_cnt == 32'd0)) m_to <= 1'b0;
          3'd1: begin
            m_ito  <= tmr_writedata[0];
            m_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) m_run <= 1'b1;
            if (tmr_writedata[3]) m_run <= 1'b0;
          end
          3'd2: begin m_per_l <= tmr_writedata; m_run <= 1'b0; m_cnt <= {m_per_h, tmr_writedata}; end
          3'd3: begin m_per_h <= tmr_writedata; m_run <= 1'b0; m_cnt <= {tmr_writedata, m_per_l}; end
          3'd4, 3'd5: begin m_snap_l <= SNAP_FORCE[15:0]; m_snap_h <= SNAP_FORCE[31:16]; end
          default: ;
        endcase
      end
      if (tmr_chipselect && tmr_write_n) begin
        case (tmr_address)
          3'd4:    tmr_readdata <= m_snap_l;
          3'd5:    tmr_readdata <= m_snap_h;
          default: tmr_readdata <= 16'd0;
        endcase
      end
    end
  end

  assign tmr_irq = m_to & m_ito;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // {cs, wn, addr, wd}
  function automatic logic [20:0] bus_word();
    return {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
  endfunction

  function automatic logic [20:0] bw(input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] d);
    return {cs, wn, a, d};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        cfg_req;
    logic [31:0] cfg_load;
    logic        snap_req;
    logic [20:0] bus;
    logic        ack;
    logic        sv;
    logic        busy;
    logic        tick;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic cr, input logic [31:0] cl, input logic sr,
                              input logic [20:0] b, input logic ack, input logic sv, input logic bz);
    vec_t v;
    v.cfg_req = cr; v.cfg_load = cl; v.snap_req = sr;
    v.bus = b; v.ack = ack; v.sv = sv; v.busy = bz; v.tick = 1'b0;
    return v;
  endfunction

  task automatic drive_vec(input int i);
    cfg_req  = vecs[i].cfg_req;
    cfg_load = vecs[i].cfg_load;
    snap_req = vecs[i].snap_req;
  endtask

  task automatic check_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    check(nm, {43'd0, bus_word(), cfg_ack, snap_valid, busy, tick},
              {43'd0, vecs[i].bus, vecs[i].ack, vecs[i].sv, vecs[i].busy, vecs[i].tick});
  endtask

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  // ---------------- test sequence ----------------
  initial begin
    logic [20:0] idle_b;
    int ack_n, ticks, last_t, rise_t, ack_t, sv_t, sv_cnt;
    logic irq_prev, found;

    idle_b = bw(1'b0, 1'b1, 3'd0, 16'd0);
    vecs[0]  = mk(0, 0, 0, idle_b, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, bw(1, 0, 3'd2, 16'hEA5F), 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, bw(1, 0, 3'd3, 16'h0000), 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, bw(1, 0, 3'd0, 16'h0000), 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, bw(1, 0, 3'd1, 16'h0007), 0, 0, 1);
    vecs[5]  = mk(1, 32'h0001_86A0, 0, idle_b, 0, 0, 0);
    vecs[6]  = mk(1, 32'h0001_86A0, 0, bw(1, 0, 3'd2, 16'h86A0), 0, 0, 1);
    vecs[7]  = mk(1, 32'h0001_86A0, 0, bw(1, 0, 3'd3, 16'h0001), 0, 0, 1);
    vecs[8]  = mk(1, 32'h0001_86A0, 0, bw(1, 0, 3'd0, 16'h0000), 0, 0, 1);
    vecs[9]  = mk(1, 32'h0001_86A0, 0, bw(1, 0, 3'd1, 16'h0007), 0, 0, 1);
    vecs[10] = mk(1, 32'h0001_86A0, 0, idle_b, 1, 0, 0);
    vecs[11] = mk(0, 0, 1, idle_b, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, bw(1, 0, 3'd4, 16'h0000), 0, 0, 1);
    vecs[13] = mk(0, 0, 1, bw(1, 1, 3'd4, 16'h0000), 0, 0, 1);
    vecs[14] = mk(0, 0, 1, bw(1, 1, 3'd5, 16'h0000), 0, 0, 1);
    vecs[15] = mk(0, 0, 1, idle_b, 0, 0, 1);
    vecs[16] = mk(0, 0, 1, idle_b, 0, 1, 0);
    vecs[17] = mk(0, 0, 0, idle_b, 0, 0, 0);

    reset_n = 1'b0; cfg_req = 1'b0; cfg_load = 32'd0; snap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tick_count", {32'd0, tick_count}, 64'd0);
    check("reset_snap_value", {32'd0, snap_value}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Boot, reprogram to 0x186A0, snapshot, all cycle by cycle
    for (int i = 0; i < 18; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      check_vec(i);
      if (i == 16) check("snap_value", {32'd0, snap_value}, {32'd0, SNAP_FORCE});
      check(i == 16 ? "tick_count_table_end" : "tick_count_table", {32'd0, tick_count}, 64'd0);
      drive_vec(i);
    end

    // Reprogram to load 9: ack latency, then 5 periods of 10 cycles
    cfg_load = 32'd9; cfg_req = 1'b1;
    ack_n = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (cfg_ack) begin ack_n = n; break; end
    end
    check("cfg_ack_latency", 64'(ack_n), 64'd5);
    cfg_req = 1'b0;

    ticks = 0; last_t = 0; rise_t = -100; irq_prev = 1'b0;
    for (int n = 0; n < 100 && ticks < 5; n++) begin
      @(posedge clk); #1;
      if (tmr_irq && !irq_prev) rise_t = n;
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0)
        check("irq_clear_latency", 64'(n), 64'(rise_t + 1));
      if (tick) begin
        if (ticks > 0) check("tick_period", 64'(n - last_t), 64'd10);
        last_t = n;
        ticks++;
      end
      irq_prev = tmr_irq;
    end
    check("tick_seen_5", 64'(ticks), 64'd5);
    check("tick_count_5", {32'd0, tick_count}, 64'd5);

    // irq, cfg_req and snap_req together: IRQ_CLR, program, snapshot
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (tmr_irq) begin found = 1'b1; break; end
    end
    check("irq_rise_found", {63'd0, found}, 64'd1);
    cfg_load = 32'h0001_86A0; cfg_req = 1'b1; snap_req = 1'b1;
    exp_q = '{4'h0, 4'h2, 4'h3, 4'h0, 4'h1, 4'h4, 4'hC, 4'hD};
    got_q.delete();
    ticks = 0; ack_t = -1; sv_t = -1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (tmr_chipselect) got_q.push_back({tmr_write_n, tmr_address});
      if (tick) ticks++;
      if (cfg_ack) begin ack_t = n; cfg_req = 1'b0; end
      if (snap_valid) begin
        sv_t = n; snap_req = 1'b0;
        check("snap_value_concurrent", {32'd0, snap_value}, {32'd0, SNAP_FORCE});
      end
    end
    check("order_len", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < 8; k++) begin
      if (got_q.size() == 0) break;
      check($sformatf("order%0d", k), {60'd0, got_q.pop_front()}, {60'd0, exp_q.pop_front()});
    end
    check("concurrent_one_tick", 64'(ticks), 64'd1);
    check("ack_before_snap", {63'd0, (ack_t >= 0 && sv_t > ack_t)}, 64'd1);
    check("tick_count_6", {32'd0, tick_count}, 64'd6);

    // Reset during SNAP_RL aborts the snapshot and restarts boot
    snap_req = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (tmr_chipselect && tmr_write_n && tmr_address == 3'd4) begin found = 1'b1; break; end
    end
    check("snap_rl_found", {63'd0, found}, 64'd1);
    reset_n = 1'b0;
    snap_req = 1'b0;
    #1;
    check("midreset_bus", {43'd0, bus_word()}, {43'd0, idle_b});
    check("midreset_tick_count", {32'd0, tick_count}, 64'd0);
    sv_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (snap_valid) sv_cnt++;
      check($sformatf("reboot_bus%0d", i), {43'd0, bus_word()}, {43'd0, vecs[i].bus});
    end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (snap_valid || cfg_ack) sv_cnt++;
    end
    check("reboot_no_valid_ack", 64'(sv_cnt), 64'd0);

    // Load value 0 is replaced by 1
    cfg_load = 32'd0; cfg_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      case (n)
        1: check("load0_period_l", {43'd0, bus_word()}, {43'd0, bw(1, 0, 3'd2, 16'h0001)});
        2: check("load0_period_h", {43'd0, bus_word()}, {43'd0, bw(1, 0, 3'd3, 16'h0000)});
        3: check("load0_status",   {43'd0, bus_word()}, {43'd0, bw(1, 0, 3'd0, 16'h0000)});
        4: check("load0_control",  {43'd0, bus_word()}, {43'd0, bw(1, 0, 3'd1, 16'h0007)});
        default: check("load0_ack", {63'd0, cfg_ack}, 64'd1);
      endcase
    end
    cfg_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sys_clk_timer_ctrl.md
# sys_clk_timer_ctrl

Avalon-MM master sequencer that owns the s1 slave port of the system interval timer. It programs the timer at boot, services its interrupt in hardware, and converts each timeout into a one-cycle `tick` pulse plus a free-running tick count. It also lets one requester reprogram the period and lets another request an atomic 32-bit counter snapshot. The block sits between the timer and the fabric logic that needs a periodic time base.

## Interface
Parameters:
- `DEFAULT_LOAD`, 59999: 32-bit load value written at boot. Timer period is load+1 clocks.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tmr_address` out 3: timer register select.
- `tmr_chipselect` out 1: timer select.
- `tmr_write_n` out 1: active-low write strobe.
- `tmr_writedata` out 16: timer write data.
- `tmr_readdata` in 16: timer read data, registered in the timer, valid 1 cycle after the address.
- `tmr_irq` in 1: timer interrupt, level.
- `cfg_req` in 1: reprogram request. Held high until `cfg_ack`.
- `cfg_load` in 32: new load value. Sampled when the request is accepted.
- `cfg_ack` out 1: 1-cycle pulse when the new period is running.
- `snap_req` in 1: snapshot request. Held high until `snap_valid`.
- `snap_valid` out 1: 1-cycle pulse; `snap_value` is valid in that cycle.
- `snap_value` out 32: captured counter value. Held until the next snapshot.
- `tick` out 1: 1-cycle pulse per serviced timeout.
- `tick_count` out 32: serviced timeouts, wraps 0xFFFFFFFF→0.
- `busy` out 1: FSM is not in IDLE.

## Operation
- Timer register map: 0 status (write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h. A write to 4 or 5 captures the counter.
- Bus: each FSM state drives at most one access. Writes use cs=1, write_n=0. Reads use cs=1, write_n=1. In IDLE: cs=0, write_n=1, address=0, writedata=0.
- States: IDLE, PRG_L, PRG_H, PRG_ST, PRG_CTL, IRQ_CLR, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP.
- After reset the FSM goes to PRG_L with the load value = `DEFAULT_LOAD`.
- Program sequence:
  - PRG_L writes load[15:0] to address 2.
  - PRG_H writes load[31:16] to address 3. The period write stops and reloads the timer.
  - PRG_ST writes 0 to address 0, discarding any stale timeout.
  - PRG_CTL writes 0x7 (START|CONT|ITO) to address 1, then returns to IDLE.
  - `cfg_ack` pulses in the cycle after PRG_CTL, for request-initiated runs only (not the boot run).
- Load value 0 is replaced by 1; a zero period would yield only one timeout.
- IRQ_CLR writes 0 to address 0. In the next cycle: `tick`=1, `tick_count`+1, return to IDLE.
- Snapshot sequence:
  - SNAP_WR writes to address 4.
  - SNAP_RL reads address 4.
  - SNAP_RH reads address 5 and captures `tmr_readdata` into `snap_value[15:0]`.
  - SNAP_CAP captures `snap_value[31:16]`, pulses `snap_valid`, then returns to IDLE.
- IDLE arbitration, fixed priority: `tmr_irq` > `cfg_req` > `snap_req`. A lower-priority request waits; none is dropped.
- `tmr_irq` arriving mid-sequence is serviced on the next return to IDLE. Multiple timeouts during a sequence collapse to one tick; the timer latches a single flag.

## Timing
- All outputs are registered. Reset values: all 0, except `tmr_write_n`=1. FSM state is PRG_L.
- Boot: first write in the first cycle after reset deasserts; timer running after 4 cycles.
- IRQ service latency: the irq sampled high in IDLE at cycle T gives the clear write at T+1 and `tick` at T+2. `tmr_irq` is low from T+2, so IDLE never re-services the same timeout.
- Reprogram: `cfg_req` seen in IDLE at T gives writes at T+1..T+4 and `cfg_ack` at T+5.
- Snapshot: `snap_req` seen at T gives `snap_valid` at T+5.
- `cfg_req`/`snap_req` must be held until their ack. A request still high in the cycle after its ack is treated as a new request.
- Reset mid-sequence aborts the sequence and restarts boot programming with `DEFAULT_LOAD`. `tick_count` returns to 0.

## Structure
- Shared package `sys_clk_timer_pkg`: register address constants, control bit positions, the state enum, and `CTL_RUN` = 4'h7.
- Single flat module with one FSM, a load-value register and a bus output register. No sub-module is warranted.

## Test plan
- Reset release with `DEFAULT_LOAD`=59999 -> writes (2,0xEA5F), (3,0x0000), (0,0), (1,0x7) on consecutive cycles. No `cfg_ack`.
- Model timer with load 9 -> `tick` every 10 cycles. `tick_count` is 5 after 5 periods. Each status clear happens 1 cycle after irq is seen.
- `cfg_req` with load 0x0001_86A0 -> writes 0x86A0, 0x0001, status, control. `cfg_ack` 5 cycles after acceptance; new tick spacing 100001.
- `cfg_load`=0 -> period_l written as 1, period_h as 0.
- `snap_req` with timer counter 0x0001_2345 at the capture write -> `snap_valid` with `snap_value`=0x00012345.
- irq, `cfg_req` and `snap_req` asserted in the same cycle -> order is IRQ_CLR, program, snapshot. Exactly one tick. Reset asserted during SNAP_RL -> no `snap_valid`, boot sequence restarts.
